// File: rtl/product_accumulator.sv
// Saturating accumulator that sums a programmed block of signed Booth-multiplier
// products and hands the block result downstream over a valid/ready handshake.
module product_accumulator #(
    parameter int N     = 32,
    parameter int ACC_W = 72,
    parameter int LEN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        block_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [2*N-1:0]   in_prod,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_acc,
    output logic                    out_sat,
    output logic [LEN_W-1:0]        out_count,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]        count_q, count_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic                    sat_q, sat_d;
    logic                    in_ready_q, out_valid_q, busy_q;
    logic [ACC_W:0]          add_res;
    logic [LEN_W-1:0]        count_inc;

    // Returns {clamped_flag, result}; one guard bit is enough because ACC_W >= 2N.
    function automatic logic [ACC_W:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [2*N-1:0]   p
    );
        logic [ACC_W:0] s;
        logic [ACC_W:0] r;
        s = {a[ACC_W-1], a} + {{(ACC_W+1-2*N){p[2*N-1]}}, p};
        if (s[ACC_W] != s[ACC_W-1]) begin
            r = s[ACC_W] ? {1'b1, 1'b1, {(ACC_W-1){1'b0}}}
                         : {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            r = {1'b0, s[ACC_W-1:0]};
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        len_d     = len_q;
        sat_d     = sat_q;
        add_res   = sat_add(acc_q, in_prod);
        count_inc = count_q + LEN_W'(1);
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = block_len;
                    acc_d   = '0;
                    count_d = '0;
                    sat_d   = 1'b0;
                    state_d = (block_len != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                if (in_valid && in_ready_q) begin
                    acc_d   = $signed(add_res[ACC_W-1:0]);
                    sat_d   = sat_q | add_res[ACC_W];
                    count_d = count_inc;
                    if (count_inc == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they never depend on inputs combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            len_q       <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            len_q       <= len_d;
            sat_q       <= sat_d;
            in_ready_q  <= (state_d == ACCUM);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_acc   = acc_q;
    assign out_sat   = sat_q;
    assign out_count = count_q;

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
Downstream consumer of the signed 2N-bit products from the sequential Booth multiplier.
- Sums a programmed block of products into a signed, saturating accumulator.
- Presents the block result with a valid/ready handshake.
- Sits between the multiplier output and the result/writeback logic, turning the multiplier into a dot-product/MAC engine.

Parameters:
N, 32, multiplier operand width; product input width is 2N
ACC_W, 72, signed accumulator width; must be >= 2N (default 2N+8 gives 256 guard terms)
LEN_W, 8, width of block length and term counter

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a new block; sampled only in IDLE
block_len  in  LEN_W  number of products in the block; latched on accepted start
in_valid  in  1  in_prod holds a valid product
in_ready  out  1  block accepts a product this cycle
in_prod  in  2N  signed two's-complement product
out_valid  out  1  block result available
out_ready  in  1  consumer takes the result
out_acc  out  ACC_W  signed accumulated sum (saturated)
out_sat  out  1  sticky: saturation occurred at least once in this block
out_count  out  LEN_W  number of products accepted in this block
busy  out  1  high in ACCUM or DONE

Behaviour:
- Reset: synchronous, active-high, overrides everything including mid-block operation.
  - State goes to IDLE; acc, count, len and sat are cleared to 0.
  - in_ready, out_valid and busy are 0.
  - Any partial sum is discarded.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start=1: latch len=block_len, clear acc, count and sat.
  - Next state is ACCUM if block_len!=0, else DONE (zero-length block yields acc=0, count=0).
- ACCUM:
  - in_ready=1.
  - On in_valid&in_ready: acc <= sat(acc + sign_extend(in_prod) to ACC_W); count <= count+1.
  - If count+1==len, next state is DONE.
  - start is ignored in this state.
- Saturation:
  - Compute the sum at ACC_W+1 bits.
  - If it exceeds 2^(ACC_W-1)-1, clamp to max; if below -2^(ACC_W-1), clamp to min.
  - Set sat=1 on either clamp; sat stays 1 until the next accepted start or reset.
  - Later products keep accumulating from the clamped value.
- DONE:
  - out_valid=1; out_acc, out_sat and out_count are stable, and held while out_ready=0.
  - On out_valid&out_ready: next state IDLE, out_valid drops next cycle.
  - start in DONE is ignored, including in the handshake cycle; the source must re-assert start in IDLE.
- Latency: out_valid rises the cycle after the last product is accepted (1-cycle registered). Zero-length block: out_valid rises the cycle after start.
- Throughput: one product per cycle in ACCUM. Minimum block overhead is 2 cycles (start + drain handshake).
- in_ready is a registered function of state only; it does not depend on in_valid.
- out_acc, out_sat and out_count keep their last value in IDLE; they are only meaningful while out_valid=1.
- The counter never wraps: len is at most 2^LEN_W-1 and DONE is entered exactly at count==len.

Test Plan:
1. Basic block, N=32: start with block_len=3, products 6, -15, 100 back-to-back -> out_valid 1 cycle after the third product; out_acc=91, out_count=3, out_sat=0.
2. Bubbles and backpressure: block_len=2, in_valid gaps of 3 cycles, products 0x7FFF_FFFF_0000_0001 twice; out_ready low for 5 cycles -> out_acc=0x0_FFFF_FFFE_0000_0002 (sign-extended), held stable until out_ready, then IDLE next cycle.
3. Saturation with N=8, ACC_W=16: block_len=4, products 16129 (127*127) four times -> out_acc=32767, out_sat=1. Repeat with -16256 x3 -> out_acc=-32768, out_sat=1. Next block with small values -> out_sat=0.
4. Zero-length block: start with block_len=0 -> in_ready never rises; out_valid the next cycle with out_acc=0, out_count=0.
5. Reset mid-block: block_len=5, accept 2 products, assert rst for 1 cycle -> in_ready=0, out_valid=0, busy=0. New block_len=1, product 7 -> out_acc=7 (no residue).
6. Ignored start: assert start during ACCUM and in the DONE handshake cycle -> len and acc unchanged; FSM returns to IDLE and needs a fresh start.
